// File: rtl/registrador_acumulado_pkg.sv
// Shared types and defaults for the accumulated-result register stage that feeds the operand MUX.
package registrador_acumulado_pkg;

    localparam int WIDTH_DEF  = 8;
    localparam int FLAG_W_DEF = 4;

    typedef enum logic [1:0] {
        VAZIO = 2'b00,
        EXEC  = 2'b01,
        ACUM  = 2'b10
    } estado_t;

    // An aborted op (timeout) returns to wherever it came from.
    function automatic estado_t estado_de_origem(input logic origem);
        return origem ? ACUM : VAZIO;
    endfunction

endpackage

// File: rtl/registrador_acumulado_contador_timeout.sv
// Wait counter for EXEC: restarts at 0 on entry and flags the last allowed cycle.
module contador_timeout #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic expirou
);

    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] LIMITE = CW'(TIMEOUT - 1);

    logic [CW-1:0] conta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conta <= '0;
        end else if (clr) begin
            conta <= '0;
        end else if (en && (conta != LIMITE)) begin
            conta <= conta + CW'(1);
        end
    end

    assign expirou = en && (conta == LIMITE);

endmodule

// File: rtl/registrador_acumulado.sv
// Holds the last ALU result for chained operations and sequences one ALU op per start request.
module registrador_acumulado
    import registrador_acumulado_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int FLAG_W  = FLAG_W_DEF,
    parameter int CNT_W   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              clear,
    input  logic [WIDTH-1:0]  alu_result,
    input  logic [FLAG_W-1:0] alu_flags,
    input  logic              alu_done,
    output logic              alu_start,
    output logic              sel,
    output logic [WIDTH-1:0]  resultado_anterior,
    output logic [FLAG_W-1:0] flags_reg,
    output logic [CNT_W-1:0]  op_count,
    output logic              busy,
    output logic              done,
    output logic              erro
);

    estado_t estado, proximo;
    logic    origem;
    logic    aceita_start, captura, limpa, estourou;
    logic    expirou;

    contador_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .en      (estado == EXEC),
        .clr     (estado != EXEC),
        .expirou (expirou)
    );

    // clear beats everything; inside EXEC a completion beats the timeout on the same cycle
    always_comb begin
        proximo      = estado;
        aceita_start = 1'b0;
        captura      = 1'b0;
        limpa        = 1'b0;
        estourou     = 1'b0;
        case (estado)
            VAZIO, ACUM: begin
                if (clear) begin
                    limpa   = 1'b1;
                    proximo = VAZIO;
                end else if (start) begin
                    aceita_start = 1'b1;
                    proximo      = EXEC;
                end
            end
            EXEC: begin
                if (clear) begin
                    limpa   = 1'b1;
                    proximo = VAZIO;
                end else if (alu_done) begin
                    captura = 1'b1;
                    proximo = ACUM;
                end else if (expirou) begin
                    estourou = 1'b1;
                    proximo  = estado_de_origem(origem);
                end
            end
            default: proximo = VAZIO;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado             <= VAZIO;
            origem             <= 1'b0;
            alu_start          <= 1'b0;
            done               <= 1'b0;
            erro               <= 1'b0;
            resultado_anterior <= '0;
            flags_reg          <= '0;
            op_count           <= '0;
        end else begin
            estado    <= proximo;
            alu_start <= aceita_start;
            done      <= captura;
            if (aceita_start) begin
                origem <= (estado == ACUM);
                erro   <= 1'b0;
            end
            if (limpa) begin
                resultado_anterior <= '0;
                flags_reg          <= '0;
                op_count           <= '0;
                erro               <= 1'b0;
            end
            if (captura) begin
                resultado_anterior <= alu_result;
                flags_reg          <= alu_flags;
                if (op_count != '1) begin
                    op_count <= op_count + CNT_W'(1);
                end
            end
            if (estourou) begin
                erro <= 1'b1;
            end
        end
    end

    // origem is frozen for the whole op so the MUX output cannot glitch mid-operation
    assign sel  = (estado == ACUM) || ((estado == EXEC) && origem);
    assign busy = (estado == EXEC);

endmodule
